// File: rtl/call_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : elev_pkg
//  Purpose  : Shared constants, state encoding and helpers for the elevator
//             call scheduler.
//  Contents : NUM_FLOORS, NO_FLOOR, DIR_UP/DIR_DOWN, sched_state_t,
//             floor_mask() (one-hot of a floor, zero for NO_FLOOR).
//  Revision : 1.0 - initial release
// ============================================================================
package elev_pkg;

   localparam int         NUM_FLOORS = 7;
   localparam logic [2:0] NO_FLOOR   = 3'b111;
   localparam logic       DIR_UP     = 1'b0;
   localparam logic       DIR_DOWN   = 1'b1;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SERVE_UP   = 2'd1,
      SERVE_DOWN = 2'd2,
      DWELL      = 2'd3
   } sched_state_t;

   // One-hot mask for a floor; NO_FLOOR maps to an empty mask so callers
   // never index past the last stop.
   function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [2:0] f);
      floor_mask = (f == NO_FLOOR) ? '0 : (NUM_FLOORS'(1) << f);
   endfunction

endpackage
`default_nettype wire

// File: rtl/call_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : call_scheduler_if
//  Purpose  : Bundle of button/switch inputs and motion-block outputs of the
//             call scheduler.
//  Signals  : call[6:0], current[2:0], door_open, ovld  (into scheduler)
//             sel[2:0], direction, pending[6:0], busy  (out of scheduler)
//  Modports : slave  - the scheduler itself
//             master - the environment driving buttons and car position
//  Revision : 1.0 - initial release
// ============================================================================
interface call_scheduler_if;
   import elev_pkg::*;

   logic [NUM_FLOORS-1:0] call;
   logic [2:0]            current;
   logic                  door_open;
   logic                  ovld;
   logic [2:0]            sel;
   logic                  direction;
   logic [NUM_FLOORS-1:0] pending;
   logic                  busy;

   modport slave (
      input  call, current, door_open, ovld,
      output sel, direction, pending, busy
   );

   modport master (
      output call, current, door_open, ovld,
      input  sel, direction, pending, busy
   );

endinterface
`default_nettype wire

// File: rtl/call_scheduler_floor_search.sv
`default_nettype none
// ============================================================================
//  Module   : floor_search
//  Purpose  : Combinational nearest-call search around the current floor.
//  Ports    : i_pending[6:0]  outstanding calls
//             i_current[2:0]  occupied floor, NO_FLOOR = unknown
//             o_above/_vld    lowest pending floor strictly above current
//             o_below/_vld    highest pending floor strictly below current
//  Revision : 1.0 - initial release
// ============================================================================
module floor_search
   import elev_pkg::*;
(
   input  logic [NUM_FLOORS-1:0] i_pending,
   input  logic [2:0]            i_current,
   output logic [2:0]            o_above,
   output logic                  o_above_vld,
   output logic [2:0]            o_below,
   output logic                  o_below_vld
);

   always_comb begin
      o_above     = NO_FLOOR;
      o_above_vld = 1'b0;
      o_below     = NO_FLOOR;
      o_below_vld = 1'b0;
      if (i_current != NO_FLOOR) begin
         // Scan top-down so the last hit is the nearest floor above.
         for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (i_pending[i] && (3'(i) > i_current)) begin
               o_above     = 3'(i);
               o_above_vld = 1'b1;
            end
         end
         // Scan bottom-up so the last hit is the nearest floor below.
         for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i_pending[i] && (3'(i) < i_current)) begin
               o_below     = 3'(i);
               o_below_vld = 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/call_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : call_scheduler
//  Purpose  : Latches hall/car calls and picks the next stop with a SCAN
//             policy; holds the car at each served stop for a fixed dwell.
//  Ports    : CLOCK_50 - system clock (rising edge)
//             reset    - synchronous, active-high
//             bus      - call_scheduler_if.slave (call, current, door_open,
//                        ovld in; sel, direction, pending, busy out)
//  Params   : DWELL_CYCLES - clock cycles the car is held at a served stop
//  Options  : CALL_CANCEL_EN - when defined, a new press of an already
//             pending call cancels it (toggle-to-cancel).
//  Revision : 1.0 - initial release
// ============================================================================
module call_scheduler
   import elev_pkg::*;
#(
   parameter int DWELL_CYCLES = 50_000_000
)(
   input  wire logic        CLOCK_50,
   input  wire logic        reset,
   call_scheduler_if.slave  bus
);

   localparam int              CNT_W    = $clog2(DWELL_CYCLES + 1);
   localparam logic [CNT_W-1:0] c_reload = CNT_W'(DWELL_CYCLES - 1);

   sched_state_t          r_state;
   logic [NUM_FLOORS-1:0] r_call_q;
   logic [NUM_FLOORS-1:0] r_pending;
   logic [2:0]            r_sel;
   logic                  r_dir;
   logic [CNT_W-1:0]      r_cnt;

   logic [NUM_FLOORS-1:0] w_rise;
   logic [NUM_FLOORS-1:0] w_set;
   logic [NUM_FLOORS-1:0] w_cancel;
   logic [NUM_FLOORS-1:0] w_clr;
   logic [NUM_FLOORS-1:0] w_cur_mask;
   logic                  w_here;
   logic                  w_arrive;
   logic                  w_hold;
   logic [2:0]            w_above;
   logic                  w_above_vld;
   logic [2:0]            w_below;
   logic                  w_below_vld;
   sched_state_t          w_leave_state;
   logic [2:0]            w_leave_sel;
   logic                  w_leave_dir;

   floor_search u_floor_search (
      .i_pending   (r_pending),
      .i_current   (bus.current),
      .o_above     (w_above),
      .o_above_vld (w_above_vld),
      .o_below     (w_below),
      .o_below_vld (w_below_vld)
   );

   assign w_rise     = bus.call & ~r_call_q;
   assign w_cur_mask = floor_mask(bus.current);
   assign w_here     = |(r_pending & w_cur_mask);
   assign w_arrive   = (bus.current != NO_FLOOR) && (bus.current == r_sel);
   assign w_hold     = bus.ovld | bus.door_open;

`ifdef CALL_CANCEL_EN
   assign w_set    = w_rise & ~r_pending;
   assign w_cancel = w_rise &  r_pending;
`else
   assign w_set    = w_rise;
   assign w_cancel = '0;
`endif

   // Served-floor clear; applied after set/cancel so it wins over a press
   // of the stop being entered or dwelt at.
   always_comb begin
      w_clr = '0;
      case (r_state)
         IDLE:                 if (w_here)   w_clr = w_cur_mask;
         SERVE_UP, SERVE_DOWN: if (w_arrive) w_clr = w_cur_mask;
         DWELL:                w_clr = floor_mask(r_sel);
         default:              w_clr = '0;
      endcase
   end

   // SCAN continuation: keep the present direction while calls lie ahead,
   // otherwise reverse, otherwise go idle. Used on dwell exit and while
   // serving (where the present direction is the serving direction).
   always_comb begin
      w_leave_state = IDLE;
      w_leave_sel   = NO_FLOOR;
      w_leave_dir   = r_dir;
      if (r_dir == DIR_UP) begin
         if (w_above_vld) begin
            w_leave_state = SERVE_UP;
            w_leave_sel   = w_above;
            w_leave_dir   = DIR_UP;
         end else if (w_below_vld) begin
            w_leave_state = SERVE_DOWN;
            w_leave_sel   = w_below;
            w_leave_dir   = DIR_DOWN;
         end
      end else begin
         if (w_below_vld) begin
            w_leave_state = SERVE_DOWN;
            w_leave_sel   = w_below;
            w_leave_dir   = DIR_DOWN;
         end else if (w_above_vld) begin
            w_leave_state = SERVE_UP;
            w_leave_sel   = w_above;
            w_leave_dir   = DIR_UP;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state   <= IDLE;
         r_sel     <= NO_FLOOR;
         r_dir     <= DIR_UP;
         r_cnt     <= '0;
         r_call_q  <= '0;
         r_pending <= '0;
      end else begin
         r_call_q  <= bus.call;
         r_pending <= ((r_pending | w_set) & ~w_cancel) & ~w_clr;

         case (r_state)
            IDLE: begin
               if (w_here) begin
                  r_state <= DWELL;
                  r_sel   <= bus.current;
                  r_cnt   <= c_reload;
               end else if (w_above_vld) begin
                  r_state <= SERVE_UP;
                  r_sel   <= w_above;
                  r_dir   <= DIR_UP;
               end else if (w_below_vld) begin
                  r_state <= SERVE_DOWN;
                  r_sel   <= w_below;
                  r_dir   <= DIR_DOWN;
               end
            end

            SERVE_UP, SERVE_DOWN: begin
               // Unknown position: hold the last target until it is valid.
               if (bus.current != NO_FLOOR) begin
                  if (w_arrive) begin
                     r_state <= DWELL;
                     r_sel   <= bus.current;
                     r_cnt   <= c_reload;
                  end else begin
                     r_state <= w_leave_state;
                     r_sel   <= w_leave_sel;
                     r_dir   <= w_leave_dir;
                  end
               end
            end

            DWELL: begin
               if (w_hold) begin
                  r_cnt <= c_reload;
               end else if (r_cnt == '0) begin
                  r_state <= w_leave_state;
                  r_sel   <= w_leave_sel;
                  r_dir   <= w_leave_dir;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end

            default: begin
               r_state <= IDLE;
               r_sel   <= NO_FLOOR;
            end
         endcase
      end
   end

   assign bus.sel       = r_sel;
   assign bus.direction = r_dir;
   assign bus.pending   = r_pending;
   assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_call_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_call_scheduler
//  Purpose  : Self-checking bench for call_scheduler (DWELL_CYCLES = 4).
//             Directed scenarios followed by randomized button/car activity,
//             all checked against a behavioural model of the SCAN rules.
//  Options  : CALL_CANCEL_EN - selects toggle-to-cancel expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_call_scheduler;

   localparam int DWELL = 4;
`ifdef CALL_CANCEL_EN
   localparam bit CANCEL = 1'b1;
`else
   localparam bit CANCEL = 1'b0;
`endif

   logic clk;
   logic rst;

   call_scheduler_if bus ();

   call_scheduler #(.DWELL_CYCLES(DWELL)) dut (
      .CLOCK_50 (clk),
      .reset    (rst),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model state
   logic [6:0] m_pend;
   logic [6:0] m_prev;
   string      m_mode;
   int         m_sel;
   int         m_dir;
   int         m_quiet;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // SCAN continuation from the model's present direction.
   task automatic pick(input int above, input int below);
      if (m_dir == 0) begin
         if (above >= 0)      begin m_mode = "UP";   m_sel = above; m_dir = 0; end
         else if (below >= 0) begin m_mode = "DOWN"; m_sel = below; m_dir = 1; end
         else                 begin m_mode = "IDLE"; m_sel = 7; end
      end else begin
         if (below >= 0)      begin m_mode = "DOWN"; m_sel = below; m_dir = 1; end
         else if (above >= 0) begin m_mode = "UP";   m_sel = above; m_dir = 0; end
         else                 begin m_mode = "IDLE"; m_sel = 7; end
      end
   endtask

   // Advances the model by one clock using the inputs about to be sampled.
   task automatic model_step();
      int         cur, above, below;
      bit         here, quiet;
      logic [6:0] nxt;
      cur = int'(bus.current);
      if (rst) begin
         m_pend = '0; m_prev = '0; m_mode = "IDLE";
         m_sel = 7; m_dir = 0; m_quiet = 0;
         return;
      end
      above = -1;
      below = -1;
      if (cur != 7) begin
         for (int f = 6; f > cur; f--) if (m_pend[f]) above = f;
         for (int f = 0; f < cur; f++) if (m_pend[f]) below = f;
      end
      here  = (cur != 7) && (m_pend[cur] == 1'b1);
      quiet = !bus.ovld && !bus.door_open;
      nxt   = m_pend;
      for (int f = 0; f < 7; f++)
         if (bus.call[f] && !m_prev[f]) nxt[f] = CANCEL ? !m_pend[f] : 1'b1;
      m_prev = bus.call;
      if (m_mode == "IDLE") begin
         if (here) begin
            m_mode = "DWELL"; m_sel = cur; nxt[cur] = 1'b0; m_quiet = 0;
         end else if (above >= 0) begin
            m_mode = "UP"; m_sel = above; m_dir = 0;
         end else if (below >= 0) begin
            m_mode = "DOWN"; m_sel = below; m_dir = 1;
         end
      end else if (m_mode == "UP" || m_mode == "DOWN") begin
         if (cur != 7) begin
            if (cur == m_sel) begin
               m_mode = "DWELL"; nxt[cur] = 1'b0; m_quiet = 0;
            end else begin
               pick(above, below);
            end
         end
      end else begin
         nxt[m_sel] = 1'b0;
         if (!quiet) m_quiet = 0;
         else begin
            m_quiet++;
            if (m_quiet == DWELL) pick(above, below);
         end
      end
      m_pend = nxt;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("sel",       8'(bus.sel),       8'(m_sel));
      chk("direction", 8'(bus.direction), 8'(m_dir));
      chk("pending",   8'(bus.pending),   8'(m_pend));
      chk("busy",      8'(bus.busy),      8'(m_mode != "IDLE"));
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic press(input logic [6:0] mask);
      bus.call = mask;
      tick();
      bus.call = '0;
      tick();
   endtask

   initial begin
      int floor_pos;
      rst           = 1'b1;
      bus.call      = '0;
      bus.current   = 3'd0;
      bus.door_open = 1'b0;
      bus.ovld      = 1'b0;
      ticks(2);
      chk("reset_sel",     8'(bus.sel),     8'h07);
      chk("reset_pending", 8'(bus.pending), 8'h00);
      chk("reset_busy",    8'(bus.busy),    8'h00);
      chk("reset_dir",     8'(bus.direction), 8'h00);
      rst = 1'b0;
      tick();

      // First call: pending after 1 cycle, target after 2.
      bus.call = 7'b0010000;
      tick();
      chk("s1_pending", 8'(bus.pending), 8'h10);
      bus.call = '0;
      tick();
      chk("s1_sel", 8'(bus.sel), 8'd4);
      chk("s1_dir", 8'(bus.direction), 8'd0);

      // Nearer call ahead retargets, then dwell at 2 and resume to 4.
      bus.current = 3'd1; tick();
      press(7'b0000100);
      chk("s2_retarget", 8'(bus.sel), 8'd2);
      bus.current = 3'd2; tick();
      chk("s2_dwell_sel", 8'(bus.sel), 8'd2);
      chk("s2_cleared",   8'(bus.pending), 8'h10);
      ticks(3);
      chk("s2_still_dwell", 8'(bus.sel), 8'd2);
      tick();
      chk("s2_resume", 8'(bus.sel), 8'd4);

      // Serve 4, go idle, then {6,1}: up to 6 first, then reverse to 1.
      bus.current = 3'd3; tick();
      bus.current = 3'd4; tick();
      ticks(DWELL);
      chk("s3_idle_busy", 8'(bus.busy), 8'd0);
      chk("s3_idle_sel",  8'(bus.sel),  8'h07);
      press(7'b1000010);
      chk("s3_up_sel", 8'(bus.sel), 8'd6);
      bus.current = 3'd5; tick();
      chk("s3_pending", 8'(bus.pending), 8'h42);
      bus.current = 3'd6; tick();
      ticks(DWELL);
      chk("s3_down_sel", 8'(bus.sel), 8'd1);
      chk("s3_down_dir", 8'(bus.direction), 8'd1);

      // Overload holds the dwell; exit exactly DWELL cycles after it drops.
      for (int f = 5; f >= 1; f--) begin
         bus.current = 3'(f);
         tick();
      end
      bus.ovld = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("s4_hold_sel", 8'(bus.sel), 8'd1);
      end
      bus.ovld = 1'b0;
      ticks(DWELL - 1);
      chk("s4_not_yet", 8'(bus.busy), 8'd1);
      tick();
      chk("s4_exit_busy", 8'(bus.busy), 8'd0);

      // Reset mid-move.
      press(7'b0101000);
      bus.current = 3'd2; tick();
      rst = 1'b1;
      tick();
      chk("s5_sel",     8'(bus.sel),     8'h07);
      chk("s5_pending", 8'(bus.pending), 8'h00);
      chk("s5_busy",    8'(bus.busy),    8'h00);
      rst = 1'b0;
      tick();

      // Second press of the only call.
      press(7'b0100000);
      chk("s6_target", 8'(bus.sel), 8'd5);
      press(7'b0100000);
`ifdef CALL_CANCEL_EN
      chk("s6_pending", 8'(bus.pending), 8'h00);
      chk("s6_sel",     8'(bus.sel),     8'h07);
      chk("s6_busy",    8'(bus.busy),    8'h00);
`else
      chk("s6_pending", 8'(bus.pending), 8'h20);
      chk("s6_sel",     8'(bus.sel),     8'd5);
      chk("s6_busy",    8'(bus.busy),    8'h01);
`endif

      // Randomized traffic: car follows the model's target one floor per
      // three cycles, with door/overload activity and position dropouts.
      floor_pos = 2;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if ((cyc % 3 == 0) && (m_mode == "UP" || m_mode == "DOWN") && m_sel != 7) begin
            if (m_sel > floor_pos)      floor_pos++;
            else if (m_sel < floor_pos) floor_pos--;
         end
         bus.current   = ($urandom % 40 == 0) ? 3'd7 : 3'(floor_pos);
         bus.call      = ($urandom % 6 == 0) ? 7'(1 << ($urandom % 7)) : 7'd0;
         bus.door_open = ($urandom % 7 == 0);
         bus.ovld      = ($urandom % 13 == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
